// File: rtl/pluck_pkg.sv
// pluck_pkg: shared state type and default timing constants for the pluck envelope
package pluck_pkg;
   typedef enum logic [1:0] {IDLE, ATTACK, DECAY} env_state_t;
   localparam int LEVEL_W_DEF    = 8;
   localparam int CLK_MHZ        = 25;
   localparam int ATTACK_DIV_DEF = CLK_MHZ * 10;
   localparam int DECAY_DIV_DEF  = CLK_MHZ * 1000;
endpackage

// File: rtl/pwm_modulator.sv
// pwm_modulator: free-running PWM compare gating the square wave by the envelope level
module pwm_modulator import pluck_pkg::*; #(
   parameter int LEVEL_W = LEVEL_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [LEVEL_W-1:0] level,
   input  logic               wave_in,
   output logic               out
);
   logic [LEVEL_W-1:0] pwm_cnt;
   always_ff @(posedge clk)
      if (reset) begin
         pwm_cnt <= '0;
         out     <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         out     <= wave_in && (pwm_cnt < level);
      end
endmodule

// File: rtl/pluck_envelope.sv
// pluck_envelope: attack-to-peak then linear-decay amplitude envelope applied to a square wave via PWM
module pluck_envelope import pluck_pkg::*; #(
   parameter int LEVEL_W     = LEVEL_W_DEF,
   parameter int PEAK        = 255,
   parameter int ATTACK_STEP = 16,
   parameter int ATTACK_DIV  = ATTACK_DIV_DEF,
   parameter int DECAY_DIV   = DECAY_DIV_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               strum,
   input  logic               wave_in,
   output logic               out,
   output logic [LEVEL_W-1:0] env_level,
   output logic               active
);
   localparam int MAX_DIV = ATTACK_DIV > DECAY_DIV ? ATTACK_DIV : DECAY_DIV;
   localparam int PW      = $clog2(MAX_DIV + 1);
   env_state_t         state;
   logic [LEVEL_W-1:0] level;
   logic [PW-1:0]      presc;
   logic [LEVEL_W:0]   sum;
   logic               tick;
   logic               at_peak;
   assign tick    = presc == (state == DECAY ? PW'(DECAY_DIV - 1) : PW'(ATTACK_DIV - 1));
   // one extra bit so the step can never wrap past the peak
   assign sum     = {1'b0, level} + (LEVEL_W + 1)'(ATTACK_STEP);
   assign at_peak = sum >= (LEVEL_W + 1)'(PEAK);
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         level <= '0;
         presc <= '0;
      end else if (strum) begin
         state <= ATTACK;
         presc <= '0;
      end else if (state == IDLE) begin
         presc <= '0;
      end else if (!tick) begin
         presc <= presc + 1'b1;
      end else if (state == ATTACK) begin
         presc <= '0;
         level <= at_peak ? LEVEL_W'(PEAK) : sum[LEVEL_W-1:0];
         state <= at_peak ? DECAY : ATTACK;
      end else begin
         presc <= '0;
         level <= level == '0 ? level : level - 1'b1;
         state <= level <= LEVEL_W'(1) ? IDLE : DECAY;
      end
   assign env_level = level;
   assign active    = state != IDLE;
   pwm_modulator #(.LEVEL_W(LEVEL_W)) u_pwm (
      .clk     (clk),
      .reset   (reset),
      .level   (level),
      .wave_in (wave_in),
      .out     (out)
   );
endmodule
